aes_block_sched: RTL and testbench
==================================

Name: aes_block_sched

Overview:
- Job-level scheduler for the iterative AES-128 round datapath inside the HWPE AES engine.
- Gathers four 32-bit words from the plaintext stream into one 128-bit block and sequences the round core through the initial AddRoundKey, rounds 1..NR and the final round.
- Captures the result and scatters it as four 32-bit words to the ciphertext stream.
- Repeats for nblocks_i blocks per job. Sits between the engine FSM and the round core.

Parameters:
- NR, 10, number of AES rounds (only 10 is supported; rcon sequence is AES-128).
- CNT_W, 16, width of the block counter and of nblocks_i.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear, same effect as reset
- start_i  in  1  job start pulse
- nblocks_i  in  CNT_W  blocks in the job, sampled on start
- busy_o  out  1  high when not in IDLE
- done_o  out  1  one-cycle job-complete pulse
- blocks_done_o  out  CNT_W  blocks completed in the current job
- in_data_i  in  32  plaintext word
- in_valid_i  in  1  plaintext word valid
- in_ready_o  out  1  plaintext word accepted
- out_data_o  out  32  ciphertext word
- out_valid_o  out  1  ciphertext word valid
- out_ready_i  in  1  ciphertext word accepted
- dp_block_o  out  128  block presented to the round core
- dp_load_o  out  1  core loads state = dp_block_o ^ key
- dp_key_load_o  out  1  core reloads the cipher key into its key register
- dp_round_en_o  out  1  core executes one round
- dp_round_idx_o  out  4  current round number
- dp_last_o  out  1  final round (core skips MixColumns)
- dp_rcon_o  out  8  round constant for on-the-fly key expansion
- dp_state_i  in  128  core state register

Behaviour:
- Reset/clear: state IDLE; all counters, buffer and outputs 0, except in_ready_o=0 and out_valid_o=0. Clear mid-job aborts with no done pulse.
- IDLE:
  - start_i with nblocks_i!=0: latch nblocks, block counter=0, go to GATHER.
  - start_i with nblocks_i==0: done_o pulses the next cycle; stay IDLE.
  - start_i outside IDLE is ignored.
- GATHER:
  - in_ready_o=1.
  - Each in_valid_i&in_ready_o handshake writes the word to buffer slot word_cnt (slot 0 = bits[31:0]) and increments word_cnt mod 4.
  - The 4th handshake goes to LOAD.
- LOAD (1 cycle):
  - dp_load_o=1, dp_round_idx_o=0.
  - dp_key_load_o=1 on every block; the key returns to round-0 key.
  - rcon register <= 0x01, round counter <= 1. Go to ROUND.
- ROUND (NR cycles):
  - dp_round_en_o=1, dp_round_idx_o=round, dp_rcon_o=rcon.
  - dp_last_o=1 when round==NR.
  - Each cycle: round++, rcon <= xtime(rcon), where xtime = (rcon<<1) ^ (rcon[7] ? 0x1b : 0).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - After the round==NR cycle, go to CAPTURE.
- CAPTURE (1 cycle): buffer <= dp_state_i; go to SCATTER.
- SCATTER:
  - out_valid_o=1, out_data_o = buffer slot word_cnt.
  - Data is stable while valid&&!ready.
  - Each handshake advances word_cnt.
  - On the 4th handshake: blocks_done_o++. If blocks_done_o+1==nblocks go to DONE, else GATHER.
- DONE (1 cycle): done_o=1; go to IDLE. blocks_done_o holds its value until the next start.
- dp_block_o = buffer at all times.
- Minimum per-block latency, first input handshake to last output handshake: 4+1+NR+1+4 = 20 cycles.
- Backpressure may stall any GATHER/SCATTER cycle indefinitely. ROUND never stalls.
- in_ready_o and out_valid_o are never high simultaneously.
- The block counter wraps at 2^CNT_W; nblocks up to 2^CNT_W-1.

Decomposition:
- aes_package:
  - aes_sched_state_t enum: IDLE, GATHER, LOAD, ROUND, CAPTURE, SCATTER, DONE.
  - AES_NR=10, AES_RCON_INIT=8'h01, AES_RCON_POLY=8'h1b.
  - xtime function.
- Optional sub-module aes_rcon_gen: rcon register with init/advance. The word buffer and counters stay inline.

Test Plan:
- FIPS-197 C.1, single block: start with nblocks=1, key 000102..0f (behavioural round core), plaintext words 33221100,77665544,bbaa9988,ffeeddcc -> out words d8e0c469,30047b6a,80b7cdd8,5ac5b470; done_o one pulse; blocks_done_o=1.
- Control trace: check dp_load_o for 1 cycle, then 10 dp_round_en_o cycles with rcon 01..36 in order, dp_last_o only at idx 10, dp_round_idx_o 1..10.
- Three blocks, no stalls -> 60 cycles first-in to last-out; blocks_done_o 1,2,3; done_o after the third.
- Random in_valid_i/out_ready_i gaps (50%) -> identical ciphertext; out_data_o stable during stalls.
- nblocks=0 -> done_o next cycle, busy_o stays 0. start_i during ROUND -> ignored.
- clear during ROUND of block 2 -> IDLE next cycle, all outputs 0, no done_o; new job of 1 block then completes correctly.

Source files
------------

// File: rtl/aes_block_sched_pkg.sv
// Shared types and constants for the AES block scheduler: FSM states,
// AES-128 round count, round-constant seed/polynomial and the xtime helper.
package aes_package;

  localparam int         AES_NR        = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1b;

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    LOAD,
    ROUND,
    CAPTURE,
    SCATTER,
    DONE
  } aes_sched_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_block_sched_rcon.sv
// Round-constant register for on-the-fly AES-128 key expansion:
// seeded to 0x01 before round 1 and multiplied by x once per round.
module aes_rcon_gen
  import aes_package::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       init_i,
  input  logic       adv_i,
  output logic [7:0] rcon_o
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rcon <= '0;
    end else if (clear) begin
      r_rcon <= '0;
    end else if (init_i) begin
      r_rcon <= AES_RCON_INIT;
    end else if (adv_i) begin
      r_rcon <= xtime(r_rcon);
    end
  end

  assign rcon_o = r_rcon;

endmodule

// File: rtl/aes_block_sched.sv
// Job-level scheduler for the iterative AES-128 round core: gathers four
// plaintext words, drives load/round control, and scatters the ciphertext.
module aes_block_sched
  import aes_package::*;
#(
  parameter int NR    = AES_NR,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start_i,
  input  logic [CNT_W-1:0] nblocks_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blocks_done_o,
  input  logic [31:0]      in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [31:0]      out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     dp_block_o,
  output logic             dp_load_o,
  output logic             dp_key_load_o,
  output logic             dp_round_en_o,
  output logic [3:0]       dp_round_idx_o,
  output logic             dp_last_o,
  output logic [7:0]       dp_rcon_o,
  input  logic [127:0]     dp_state_i
);

  aes_sched_state_t  r_state;
  logic [CNT_W-1:0]  r_nblocks;
  logic [CNT_W-1:0]  r_blocks_done;
  logic [1:0]        r_word_cnt;
  logic [3:0]        r_round;
  logic [3:0][31:0]  r_buf;
  logic              r_done;

  logic [CNT_W-1:0]  w_blocks_next;
  logic              w_last_round;
  logic [7:0]        w_rcon;

  assign w_blocks_next = r_blocks_done + 1'b1;
  assign w_last_round  = (r_round == 4'(NR));

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .init_i (r_state == LOAD),
    .adv_i  (r_state == ROUND),
    .rcon_o (w_rcon)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_nblocks     <= '0;
      r_blocks_done <= '0;
      r_word_cnt    <= '0;
      r_round       <= '0;
      r_buf         <= '0;
      r_done        <= 1'b0;
    end else if (clear) begin
      r_state       <= IDLE;
      r_nblocks     <= '0;
      r_blocks_done <= '0;
      r_word_cnt    <= '0;
      r_round       <= '0;
      r_buf         <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_blocks_done <= '0;
            r_word_cnt    <= '0;
            // An empty job completes immediately without leaving IDLE.
            if (nblocks_i != '0) begin
              r_nblocks <= nblocks_i;
              r_state   <= GATHER;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        GATHER: begin
          if (in_valid_i) begin
            r_buf[r_word_cnt] <= in_data_i;
            r_word_cnt        <= r_word_cnt + 1'b1;
            if (r_word_cnt == 2'd3) r_state <= LOAD;
          end
        end
        LOAD: begin
          r_round <= 4'd1;
          r_state <= ROUND;
        end
        ROUND: begin
          r_round <= r_round + 1'b1;
          if (w_last_round) r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_buf   <= dp_state_i;
          r_state <= SCATTER;
        end
        SCATTER: begin
          if (out_ready_i) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (r_word_cnt == 2'd3) begin
              r_blocks_done <= w_blocks_next;
              if (w_blocks_next == r_nblocks) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= GATHER;
              end
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;
  assign blocks_done_o  = r_blocks_done;
  assign in_ready_o     = (r_state == GATHER);
  assign out_valid_o    = (r_state == SCATTER);
  assign out_data_o     = r_buf[r_word_cnt];
  assign dp_block_o     = r_buf;
  assign dp_load_o      = (r_state == LOAD);
  assign dp_key_load_o  = (r_state == LOAD);
  assign dp_round_en_o  = (r_state == ROUND);
  assign dp_round_idx_o = (r_state == ROUND) ? r_round : 4'd0;
  assign dp_last_o      = (r_state == ROUND) && w_last_round;
  assign dp_rcon_o      = (r_state == ROUND) ? w_rcon : 8'h00;

endmodule

// File: tb/tb_aes_block_sched.sv
// Self-checking bench: behavioural AES-128 round core driven by the scheduler,
// reference encryptions computed from first principles, random backpressure.
module tb_aes_block_sched;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] nblocks_i = '0;
  logic             busy_o, done_o;
  logic [CNT_W-1:0] blocks_done_o;
  logic [31:0]      in_data_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [31:0]      out_data_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [127:0]     dp_block_o;
  logic             dp_load_o, dp_key_load_o, dp_round_en_o, dp_last_o;
  logic [3:0]       dp_round_idx_o;
  logic [7:0]       dp_rcon_o;
  logic [127:0]     dp_state_i;

  always #5 clk = ~clk;

  aes_block_sched #(.NR(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
    .nblocks_i(nblocks_i), .busy_o(busy_o), .done_o(done_o),
    .blocks_done_o(blocks_done_o), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .dp_block_o(dp_block_o),
    .dp_load_o(dp_load_o), .dp_key_load_o(dp_key_load_o),
    .dp_round_en_o(dp_round_en_o), .dp_round_idx_o(dp_round_idx_o),
    .dp_last_o(dp_last_o), .dp_rcon_o(dp_rcon_o), .dp_state_i(dp_state_i)
  );

  // ---------------- AES reference arithmetic ----------------
  logic [7:0] sbox [256];
  logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
        t[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0 = k[31:0]; w1 = k[63:32]; w2 = k[95:64]; w3 = k[127:96];
    rot = {w3[7:0], w3[31:8]};
    for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox[rot[8*i +: 8]];
    t[7:0] = t[7:0] ^ rc;
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, rk;
    s = pt ^ k; rk = k;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, RC[r-1]);
      s  = aes_round(s, rk, r == 10);
    end
    return s;
  endfunction

  // ---------------- behavioural round core ----------------
  logic [127:0] key = '0;
  logic [127:0] core_key = '0, core_st = '0;
  assign dp_state_i = core_st;

  always @(posedge clk) begin
    if (dp_key_load_o) core_key <= key;
    if (dp_load_o) core_st <= dp_block_o ^ (dp_key_load_o ? key : core_key);
    else if (dp_round_en_o) begin
      core_key <= next_key(core_key, dp_rcon_o);
      core_st  <= aes_round(core_st, next_key(core_key, dp_rcon_o), dp_last_o);
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (negedge) and driver (posedge+1) ----------------
  int           cyc = 0;
  logic [31:0]  in_words [$];
  logic [31:0]  exp_q [$];
  logic [31:0]  out_q [$];
  int           in_hs_cyc [$];
  int           out_hs_cyc [$];
  int           done_cnt = 0, done_cyc = 0;
  logic [CNT_W-1:0] bd_q [$];
  logic [CNT_W-1:0] bd_prev = '0;
  logic [15:0]  tr_q [$];
  int           tr_cyc [$];
  bit           gaps = 1'b0, in_pop = 1'b0, stall_prev = 1'b0;
  logic [31:0]  stall_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n || clear) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", out_valid_o, 1'b1);
        chk("stall_data", out_data_o, stall_data);
      end
      stall_prev = out_valid_o && !out_ready_i;
      stall_data = out_data_o;
      chk("ready_valid_excl", in_ready_o && out_valid_o, 1'b0);
      if (in_valid_i && in_ready_o) begin in_pop = 1'b1; in_hs_cyc.push_back(cyc); end
      if (out_valid_o && out_ready_i) begin
        out_q.push_back(out_data_o);
        out_hs_cyc.push_back(cyc);
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (blocks_done_o != bd_prev && blocks_done_o != '0) bd_q.push_back(blocks_done_o);
      bd_prev = blocks_done_o;
      if (dp_load_o || dp_round_en_o) begin
        tr_q.push_back({dp_load_o, dp_key_load_o, dp_round_en_o, dp_last_o,
                        dp_round_idx_o, dp_rcon_o});
        tr_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (in_pop) begin
      if (in_words.size() > 0) in_words.delete(0);
      in_pop = 1'b0;
    end
    in_valid_i  = (in_words.size() > 0) && (!gaps || $urandom_range(0, 1) == 1);
    in_data_i   = (in_words.size() > 0) ? in_words[0] : 32'h0;
    out_ready_i = !gaps || $urandom_range(0, 1) == 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [127:0] pt);
    logic [127:0] ct;
    ct = aes_enc(pt, key);
    for (int i = 0; i < 4; i++) begin
      in_words.push_back(pt[32*i +: 32]);
      exp_q.push_back(ct[32*i +: 32]);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_job(input int nb);
    logic [31:0] v;
    v = nb;
    start_i = 1'b1; nblocks_i = v[CNT_W-1:0];
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    if (done_cnt == d0) chk({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_nwords"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk({tag, "_ct"}, out_q[i], exp_q[i]);
    out_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] pt;
    logic [31:0]  fips_ct [4];
    logic [15:0]  e;
    int d0, n;

    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv, bb, cc;
      inv = 8'h00; bb = b[7:0];
      for (int c = 1; c < 256; c++) begin
        cc = c[7:0];
        if (gmul(bb, cc) == 8'h01) inv = cc;
      end
      sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    #3 reset_n = 1'b0;
    tick(2);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_blocks_done", blocks_done_o, 0);
    chk("rst_dp_block", dp_block_o, 128'h0);
    chk("rst_dp_ctl", {dp_load_o, dp_key_load_o, dp_round_en_o, dp_last_o}, 4'h0);
    chk("rst_dp_idx_rcon", {dp_round_idx_o, dp_rcon_o}, 12'h0);
    reset_n = 1'b1;
    tick(2);

    // FIPS-197 C.1 single block plus control trace
    key = 128'h0f0e0d0c0b0a09080706050403020100;
    pt  = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
    fips_ct = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470};
    push_block(pt);
    tr_q.delete(); tr_cyc.delete(); bd_q.delete();
    d0 = done_cnt;
    start_job(1);
    wait_done(d0, 200, "fips");
    tick(3);
    chk("fips_nwords", out_q.size(), 4);
    if (out_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("fips_word", out_q[i], fips_ct[i]);
    check_outs("fips_model");
    chk("fips_done_pulses", done_cnt - d0, 1);
    chk("fips_blocks_done", blocks_done_o, 1);
    chk("fips_busy_after", busy_o, 1'b0);
    chk("trace_len", tr_q.size(), 11);
    if (tr_q.size() == 11) begin
      chk("trace_load", {tr_q[0][15:8]}, 8'b1100_0000);
      for (int k = 1; k <= 10; k++) begin
        e = {1'b0, 1'b0, 1'b1, (k == 10), 4'(k), RC[k-1]};
        chk("trace_round", tr_q[k], e);
        chk("trace_contig", tr_cyc[k] - tr_cyc[0], k);
      end
    end

    // Three blocks, no stalls: 60-cycle span, block count progression
    key = rnd128();
    for (int i = 0; i < 3; i++) push_block(rnd128());
    in_hs_cyc.delete(); out_hs_cyc.delete(); bd_q.delete();
    d0 = done_cnt;
    start_job(3);
    wait_done(d0, 400, "three");
    tick(2);
    chk("three_span", out_hs_cyc.size() == 12 && in_hs_cyc.size() == 12 ?
        out_hs_cyc[11] - in_hs_cyc[0] + 1 : -1, 60);
    chk("three_done_after_last", out_hs_cyc.size() == 12 ? done_cyc - out_hs_cyc[11] : -1, 1);
    chk("three_bd_len", bd_q.size(), 3);
    if (bd_q.size() == 3)
      for (int i = 0; i < 3; i++) chk("three_bd_seq", bd_q[i], i + 1);
    chk("three_done_pulses", done_cnt - d0, 1);
    check_outs("three");

    // Random 50% gaps on both streams
    gaps = 1'b1;
    key = rnd128();
    for (int i = 0; i < 3; i++) push_block(rnd128());
    d0 = done_cnt;
    start_job(3);
    wait_done(d0, 3000, "gaps");
    tick(2);
    gaps = 1'b0;
    chk("gaps_done_pulses", done_cnt - d0, 1);
    chk("gaps_blocks_done", blocks_done_o, 3);
    check_outs("gaps");

    // Zero-length job
    d0 = done_cnt;
    start_job(0);
    chk("nb0_done", done_o, 1'b1);
    chk("nb0_busy", busy_o, 1'b0);
    tick();
    chk("nb0_done_clr", done_o, 1'b0);
    chk("nb0_busy2", busy_o, 1'b0);
    chk("nb0_blocks_done", blocks_done_o, 0);
    tick(2);
    chk("nb0_done_pulses", done_cnt - d0, 1);

    // start_i during ROUND is ignored
    key = rnd128();
    push_block(rnd128());
    d0 = done_cnt;
    start_job(1);
    n = 0;
    while (!dp_round_en_o && n < 100) begin tick(); n++; end
    chk("ign_reach_round", dp_round_en_o, 1'b1);
    start_i = 1'b1; nblocks_i = 16'd5;
    tick();
    start_i = 1'b0;
    wait_done(d0, 200, "ign");
    tick(5);
    chk("ign_done_pulses", done_cnt - d0, 1);
    chk("ign_blocks_done", blocks_done_o, 1);
    chk("ign_busy", busy_o, 1'b0);
    check_outs("ign");

    // clear during ROUND of block 2, then a fresh 1-block job
    key = rnd128();
    for (int i = 0; i < 3; i++) push_block(rnd128());
    d0 = done_cnt;
    start_job(3);
    n = 0;
    while (!(out_q.size() >= 4 && dp_round_en_o) && n < 300) begin tick(); n++; end
    chk("clr_reach_round2", out_q.size() >= 4 && dp_round_en_o, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", busy_o, 1'b0);
    chk("clr_done", done_o, 1'b0);
    chk("clr_in_ready", in_ready_o, 1'b0);
    chk("clr_out_valid", out_valid_o, 1'b0);
    chk("clr_blocks_done", blocks_done_o, 0);
    chk("clr_dp_block", dp_block_o, 128'h0);
    chk("clr_out_data", out_data_o, 32'h0);
    chk("clr_dp_ctl", {dp_load_o, dp_key_load_o, dp_round_en_o, dp_last_o}, 4'h0);
    chk("clr_dp_idx_rcon", {dp_round_idx_o, dp_rcon_o}, 12'h0);
    in_words.delete(); exp_q.delete(); out_q.delete();
    tick(20);
    chk("clr_no_done", done_cnt - d0, 0);
    key = rnd128();
    push_block(rnd128());
    d0 = done_cnt;
    start_job(1);
    wait_done(d0, 200, "post_clr");
    tick(2);
    chk("post_clr_blocks_done", blocks_done_o, 1);
    check_outs("post_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
